// File: rtl/game_pkg.sv
// Shared types and constants for the word-guess game datapath.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    CHECK,
    RESOLVE,
    WIN,
    LOSE
  } state_e;

  localparam logic [6:0] ASCII_A     = 7'h41;
  localparam logic [6:0] ASCII_Z     = 7'h5A;
  localparam int         NUM_LETTERS = 26;

endpackage

// File: rtl/guess_checker_letter_decode.sv
// Maps a 7-bit ASCII code to an alphabet index 0..25 and flags upper-case letters.
module letter_decode
  import game_pkg::*;
(
  input  logic [6:0] ascii,
  output logic [4:0] index,
  output logic       is_letter
);

  always_comb begin
    is_letter = (ascii >= ASCII_A) && (ascii <= ASCII_Z);
    // Only meaningful when is_letter is set; the offset then fits in 5 bits.
    index     = 5'(ascii - ASCII_A);
  end

endmodule

// File: rtl/guess_checker.sv
// Word-guess checker: accepts a letter, scans the secret word one position per
// cycle, and tracks revealed positions, misses, guessed letters and win/lose.
module guess_checker
  import game_pkg::*;
#(
  parameter int WORD_LEN   = 4,
  parameter int MAX_MISSES = 6,
  parameter int MISS_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  new_game,
  input  logic [7*WORD_LEN-1:0] secret_word,
  input  logic                  guess_valid,
  input  logic [6:0]            guess_ascii,
  output logic [WORD_LEN-1:0]   revealed,
  output logic [MISS_W-1:0]     miss_count,
  output logic                  busy,
  output logic                  guess_done,
  output logic                  guess_hit,
  output logic                  repeat_guess,
  output logic                  game_won,
  output logic                  game_lost
);

  localparam int                IDX_W    = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_LEN - 1);
  localparam logic [MISS_W-1:0] MAX_M    = MISS_W'(MAX_MISSES);

  function automatic logic [MISS_W-1:0] sat_inc(input logic [MISS_W-1:0] v);
    return (v >= MAX_M) ? MAX_M : v + MISS_W'(1);
  endfunction

  // Control state
  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   hit_q, hit_d;
  logic [WORD_LEN-1:0]    revealed_q, revealed_d;
  logic [MISS_W-1:0]      miss_q, miss_d;
  logic [NUM_LETTERS-1:0] guessed_q, guessed_d;
  logic                   guess_done_q, guess_done_d;
  logic                   guess_hit_q, guess_hit_d;
  logic                   repeat_q, repeat_d;

  // Datapath state: the secret word is held pre-decoded as letter indices
  logic [4:0]             word_idx_q [WORD_LEN];
  logic [4:0]             word_idx_d [WORD_LEN];
  logic [WORD_LEN-1:0]    word_let_q, word_let_d;
  logic [4:0]             letter_q, letter_d;

  logic [4:0]             in_idx [WORD_LEN];
  logic [WORD_LEN-1:0]    in_is_letter;
  logic [4:0]             g_index;
  logic                   g_is_letter;
  logic                   cur_match;

  for (genvar i = 0; i < WORD_LEN; i++) begin : g_word_dec
    letter_decode u_dec (
      .ascii     (secret_word[i*7 +: 7]),
      .index     (in_idx[i]),
      .is_letter (in_is_letter[i])
    );
  end

  letter_decode u_guess_dec (
    .ascii     (guess_ascii),
    .index     (g_index),
    .is_letter (g_is_letter)
  );

  assign cur_match = word_let_q[idx_q] && (word_idx_q[idx_q] == letter_q);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    hit_d        = hit_q;
    revealed_d   = revealed_q;
    miss_d       = miss_q;
    guessed_d    = guessed_q;
    guess_done_d = 1'b0;
    guess_hit_d  = guess_hit_q;
    repeat_d     = 1'b0;
    word_idx_d   = word_idx_q;
    word_let_d   = word_let_q;
    letter_d     = letter_q;

    if (new_game) begin
      // Non-letter positions (padding) start uncovered.
      word_idx_d  = in_idx;
      word_let_d  = in_is_letter;
      revealed_d  = ~in_is_letter;
      miss_d      = '0;
      guessed_d   = '0;
      hit_d       = 1'b0;
      idx_d       = '0;
      guess_hit_d = 1'b0;
      state_d     = (&(~in_is_letter)) ? WIN : PLAY;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (guess_valid && g_is_letter) begin
            if (guessed_q[g_index]) begin
              repeat_d = 1'b1;
            end else begin
              letter_d           = g_index;
              guessed_d[g_index] = 1'b1;
              idx_d              = '0;
              hit_d              = 1'b0;
              state_d            = CHECK;
            end
          end
        end
        CHECK: begin
          if (cur_match) begin
            revealed_d[idx_q] = 1'b1;
            hit_d             = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = RESOLVE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        RESOLVE: begin
          guess_done_d = 1'b1;
          guess_hit_d  = hit_q;
          if (!hit_q) begin
            miss_d = sat_inc(miss_q);
          end
          // Win takes precedence; a hit leaves miss_count untouched so it cannot lose.
          if (&revealed_q) begin
            state_d = WIN;
          end else if (miss_d == MAX_M) begin
            state_d = LOSE;
          end else begin
            state_d = PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      hit_q        <= 1'b0;
      revealed_q   <= '0;
      miss_q       <= '0;
      guessed_q    <= '0;
      guess_done_q <= 1'b0;
      guess_hit_q  <= 1'b0;
      repeat_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      hit_q        <= hit_d;
      revealed_q   <= revealed_d;
      miss_q       <= miss_d;
      guessed_q    <= guessed_d;
      guess_done_q <= guess_done_d;
      guess_hit_q  <= guess_hit_d;
      repeat_q     <= repeat_d;
    end
  end

  always_ff @(posedge clk) begin
    word_idx_q <= word_idx_d;
    word_let_q <= word_let_d;
    letter_q   <= letter_d;
  end

  assign revealed     = revealed_q;
  assign miss_count   = miss_q;
  assign busy         = (state_q == CHECK) || (state_q == RESOLVE);
  assign guess_done   = guess_done_q;
  assign guess_hit    = guess_hit_q;
  assign repeat_guess = repeat_q;
  assign game_won     = (state_q == WIN);
  assign game_lost    = (state_q == LOSE);

endmodule

// File: tb/tb_guess_checker.sv
// Directed bench for guess_checker with a scoreboard of expected guess results.
module tb_guess_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        new_game;
  logic [27:0] secret_word;
  logic        guess_valid;
  logic [6:0]  guess_ascii;
  logic [3:0]  revealed;
  logic [2:0]  miss_count;
  logic        busy, guess_done, guess_hit, repeat_guess, game_won, game_lost;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       hit;
    logic [2:0] miss;
    logic [3:0] rev;
    logic       won;
    logic       lost;
  } exp_t;

  exp_t sb[$];

  guess_checker #(.WORD_LEN(4), .MAX_MISSES(6), .MISS_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .new_game     (new_game),
    .secret_word  (secret_word),
    .guess_valid  (guess_valid),
    .guess_ascii  (guess_ascii),
    .revealed     (revealed),
    .miss_count   (miss_count),
    .busy         (busy),
    .guess_done   (guess_done),
    .guess_hit    (guess_hit),
    .repeat_guess (repeat_guess),
    .game_won     (game_won),
    .game_lost    (game_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every guess_done must match the oldest pending expectation.
  always @(negedge clk) begin
    if (guess_done) begin
      if (sb.size() == 0) begin
        check("unexpected_guess_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_hit",  32'(guess_hit),  32'(e.hit));
        check("sb_miss", 32'(miss_count), 32'(e.miss));
        check("sb_rev",  32'(revealed),   32'(e.rev));
        check("sb_won",  32'(game_won),   32'(e.won));
        check("sb_lost", 32'(game_lost),  32'(e.lost));
      end
    end
  end

  task automatic start_game(input logic [27:0] w);
    @(negedge clk);
    new_game    = 1'b1;
    secret_word = w;
    @(negedge clk);
    new_game    = 1'b0;
  endtask

  // Returns at the negedge of the cycle after the guess was sampled.
  task automatic pulse_guess(input logic [6:0] ch);
    @(negedge clk);
    guess_valid = 1'b1;
    guess_ascii = ch;
    @(negedge clk);
    guess_valid = 1'b0;
  endtask

  task automatic wait_done(output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      n++;
      if (guess_done) break;
      if (busy) busy_cnt++;
    end
    if (!guess_done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic guess_exp(input logic [6:0] ch, input logic hit, input logic [2:0] miss,
                           input logic [3:0] rev, input logic won, input logic lost);
    int n, b;
    sb.push_back('{hit: hit, miss: miss, rev: rev, won: won, lost: lost});
    pulse_guess(ch);
    wait_done(n, b);
  endtask

  task automatic expect_ignored(input string tag, input logic [6:0] ch,
                                input logic [3:0] rev, input logic [2:0] miss);
    pulse_guess(ch);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_repeat"}, 32'(repeat_guess), 32'd0);
    check({tag, "_rev"}, 32'(revealed), 32'(rev));
    check({tag, "_miss"}, 32'(miss_count), 32'(miss));
  endtask

  localparam logic [27:0] W_CODE  = {7'h45, 7'h44, 7'h4F, 7'h43};
  localparam logic [27:0] W_EEL   = {7'h20, 7'h4C, 7'h45, 7'h45};
  localparam logic [27:0] W_AB    = {7'h20, 7'h20, 7'h42, 7'h41};
  localparam logic [27:0] W_BLANK = {7'h20, 7'h20, 7'h20, 7'h20};

  initial begin
    int n, b;
    rst = 1'b1; new_game = 1'b0; secret_word = '0; guess_valid = 1'b0; guess_ascii = '0;
    repeat (3) @(negedge clk);
    check("rst_rev",  32'(revealed), 32'd0);
    check("rst_miss", 32'(miss_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", 32'({guess_done, guess_hit, repeat_guess, game_won, game_lost}), 32'd0);
    rst = 1'b0;

    expect_ignored("idle_guess", 7'h41, 4'b0000, 3'd0);

    // Test 1: first hit with latency
    start_game(W_CODE);
    check("code_rev0", 32'(revealed), 32'd0);
    sb.push_back('{hit: 1'b1, miss: 3'd0, rev: 4'b0010, won: 1'b0, lost: 1'b0});
    pulse_guess(7'h4F);
    check("o_busy_t1", 32'(busy), 32'd1);
    wait_done(n, b);
    check("o_latency", 32'(n), 32'd5);
    check("o_busy_cycles", 32'(b), 32'd4);
    @(negedge clk);
    check("o_done_pulse", 32'(guess_done), 32'd0);
    check("o_busy_after", 32'(busy), 32'd0);

    // Test 2: repeat
    pulse_guess(7'h4F);
    check("rep_pulse", 32'(repeat_guess), 32'd1);
    check("rep_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("rep_pulse_end", 32'(repeat_guess), 32'd0);
    check("rep_miss", 32'(miss_count), 32'd0);

    // Test 3: six misses to a loss, then guesses are ignored
    guess_exp(7'h41, 1'b0, 3'd1, 4'b0010, 1'b0, 1'b0);
    guess_exp(7'h42, 1'b0, 3'd2, 4'b0010, 1'b0, 1'b0);
    guess_exp(7'h46, 1'b0, 3'd3, 4'b0010, 1'b0, 1'b0);
    guess_exp(7'h47, 1'b0, 3'd4, 4'b0010, 1'b0, 1'b0);
    guess_exp(7'h48, 1'b0, 3'd5, 4'b0010, 1'b0, 1'b0);
    guess_exp(7'h49, 1'b0, 3'd6, 4'b0010, 1'b0, 1'b1);
    expect_ignored("lose_guess", 7'h43, 4'b0010, 3'd6);
    check("lose_hold", 32'(game_lost), 32'd1);

    // Test 4: padding pre-revealed, duplicates revealed together, win
    start_game(W_EEL);
    check("eel_rev0", 32'(revealed), 32'b1000);
    check("eel_miss0", 32'(miss_count), 32'd0);
    check("eel_flags", 32'({game_won, game_lost}), 32'd0);
    guess_exp(7'h45, 1'b1, 3'd0, 4'b1011, 1'b0, 1'b0);
    guess_exp(7'h4C, 1'b1, 3'd0, 4'b1111, 1'b1, 1'b0);
    expect_ignored("win_guess", 7'h5A, 4'b1111, 3'd0);
    check("win_hold", 32'(game_won), 32'd1);

    // Test 5: non-letters ignored; guess during CHECK dropped
    start_game(W_CODE);
    check("code2_won", 32'(game_won), 32'd0);
    expect_ignored("digit", 7'h31, 4'b0000, 3'd0);
    expect_ignored("lower", 7'h61, 4'b0000, 3'd0);
    sb.push_back('{hit: 1'b1, miss: 3'd0, rev: 4'b0100, won: 1'b0, lost: 1'b0});
    pulse_guess(7'h44);
    @(negedge clk);
    guess_valid = 1'b1; guess_ascii = 7'h43;
    @(negedge clk);
    guess_valid = 1'b0;
    wait_done(n, b);
    guess_exp(7'h43, 1'b1, 3'd0, 4'b0101, 1'b0, 1'b0);
    guess_exp(7'h5A, 1'b0, 3'd1, 4'b0101, 1'b0, 1'b0);

    // Test 6a: new_game mid-scan aborts it
    pulse_guess(7'h58);
    @(negedge clk);
    new_game = 1'b1; secret_word = W_AB;
    @(negedge clk);
    new_game = 1'b0;
    check("abort_rev", 32'(revealed), 32'b1100);
    check("abort_miss", 32'(miss_count), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);
    guess_exp(7'h58, 1'b0, 3'd1, 4'b1100, 1'b0, 1'b0);
    guess_exp(7'h41, 1'b1, 3'd1, 4'b1101, 1'b0, 1'b0);

    // All-padding word wins immediately
    start_game(W_BLANK);
    check("blank_won", 32'(game_won), 32'd1);
    check("blank_rev", 32'(revealed), 32'b1111);

    // Test 6b: rst mid-scan
    start_game(W_CODE);
    pulse_guess(7'h43);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_rev",  32'(revealed), 32'd0);
    check("rst2_miss", 32'(miss_count), 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_flags", 32'({guess_done, guess_hit, repeat_guess, game_won, game_lost}), 32'd0);
    repeat (6) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/guess_checker.md
Name: guess_checker

Overview:
- Downstream consumer of the letter selector's latched `user_ascii` in the Lab4 word-guess game.
- Takes a committed guess and scans the secret word one position per cycle.
- Maintains the revealed-position mask, the miss count and the set of letters already guessed.
- Drives win/lose status for the display and scoring logic.

Parameters:
- WORD_LEN, 4: number of letter positions in the secret word.
- MAX_MISSES, 6: wrong guesses allowed; reaching this count ends the game as a loss.
- MISS_W, 3: width of `miss_count`. Must satisfy 2^MISS_W > MAX_MISSES.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, synchronous, active-high.
- new_game, input, 1: one-cycle pulse; loads `secret_word` and starts a game.
- secret_word, input, 7*WORD_LEN: ASCII word. Bits [6:0] are position 0.
- guess_valid, input, 1: one-cycle pulse; commits `guess_ascii`.
- guess_ascii, input, 7: letter from the selector (`user_ascii`).
- revealed, output, WORD_LEN: bit i = 1 when position i has been uncovered.
- miss_count, output, MISS_W: wrong guesses so far.
- busy, output, 1: high in CHECK and RESOLVE.
- guess_done, output, 1: one-cycle pulse when a guess is resolved.
- guess_hit, output, 1: valid with `guess_done`; 1 = letter occurred in the word.
- repeat_guess, output, 1: one-cycle pulse; the guessed letter was already tried.
- game_won, output, 1: level, high in WIN.
- game_lost, output, 1: level, high in LOSE.

Behaviour:

Reset values:
- State IDLE.
- `revealed` = 0, `miss_count` = 0, guessed-set = 0.
- All pulses 0; `game_won` = 0, `game_lost` = 0.

Priority: rst > new_game > guess_valid.

new_game (honoured in any state, including mid-CHECK; aborts the current scan):
- Latch `secret_word`.
- Clear `miss_count` and the guessed-set; clear `hit`.
- `revealed[i]` = 1 where position i is not in 'A'..'Z' (7'h41..7'h5A), so space padding is pre-revealed; otherwise 0.
- Next state PLAY.
- If every position is pre-revealed, go to WIN instead.
- A `guess_valid` in the same cycle is dropped.

States:
- IDLE: ignores `guess_valid`.
- PLAY, on `guess_valid`:
  - `guess_ascii` outside 'A'..'Z': ignored, no pulse, no state change.
  - Letter's bit already set in the 26-bit guessed-set: `repeat_guess` = 1 in the next cycle, no other change; not counted as a miss.
  - Otherwise: latch the letter, set its guessed-set bit, `idx` = 0, `hit` = 0, go to CHECK.
- CHECK, one position per cycle:
  - If `word[idx]` == latched letter: set `revealed[idx]` (visible next cycle) and `hit` = 1.
  - `idx` increments; after `idx` = WORD_LEN-1, go to RESOLVE.
  - `guess_valid` is ignored while busy.
- RESOLVE, single cycle:
  - If `hit` == 0: `miss_count` += 1.
  - Assert `guess_done` and `guess_hit` = `hit` (registered).
  - If all `revealed` bits = 1: go to WIN.
  - Else if the updated `miss_count` == MAX_MISSES: go to LOSE.
  - Else: go to PLAY.
  - Win is checked before loss. A hit can never produce a loss.
- WIN / LOSE: hold all outputs; ignore guesses; exit only via new_game or rst.

Latency:
- Guess accepted at cycle T.
- CHECK occupies T+1 .. T+WORD_LEN.
- RESOLVE at T+WORD_LEN+1.
- `guess_done`, `miss_count`, `game_won`/`game_lost` visible at T+WORD_LEN+2.
- The next guess is accepted from T+WORD_LEN+2.

Width and arithmetic:
- `miss_count` saturates at MAX_MISSES; it never wraps.
- Guessed-set index = ascii − 7'h41, 5 bits.
- Duplicate letters in the word are all revealed by one guess.

Decomposition:
- Package `game_pkg`: state enum (IDLE, PLAY, CHECK, RESOLVE, WIN, LOSE), ASCII_A = 7'h41, ASCII_Z = 7'h5A, NUM_LETTERS = 26.
- Sub-module `letter_decode` (combinational): 7-bit ASCII in, 5-bit index out plus `is_letter`. Used for guess validation and for pre-reveal at new_game.
- The remainder (FSM, scan counter, masks) lives in `guess_checker`.

Test Plan (WORD_LEN=4, MAX_MISSES=6):
1. rst, then new_game with "CODE"; guess 'O' at T → `busy` T+1..T+5; at T+6 `revealed` = 4'b0010, `guess_done` = 1, `guess_hit` = 1, `miss_count` = 0.
2. Guess 'O' again in PLAY → `repeat_guess` pulse next cycle, `miss_count` unchanged, no `guess_done`.
3. Six distinct misses ('A','B','F','G','H','I') → `miss_count` = 6, `game_lost` = 1; a further guess 'C' is ignored and `revealed` stays unchanged.
4. new_game "EEL " → `revealed` = 4'b1000 immediately; guess 'E' → `revealed` = 4'b1011; guess 'L' → 4'b1111 and `game_won` = 1 on the `guess_done` cycle.
5. Guess_valid with 7'h31 ('1') or 7'h61 ('a') in PLAY → no pulse, state unchanged. Guess_valid during CHECK → dropped.
6. new_game asserted at T+2 of a CHECK scan → `revealed` and `miss_count` reloaded, `guess_done` never pulses. rst mid-CHECK → all outputs return to reset values next cycle.
